// File: rtl/nintendo_alu_bus_if_if.sv
// CPU-side and ALU-side bus signals of the protection-ALU front end.
// The slave modport is the front end; the master modport is the CPU/ALU environment.
interface nintendo_alu_bus_if_if;
    logic        cpu_m2;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_oe;
    logic [7:0]  alu_wdata;
    logic        alu_wdata_oe;
    logic        alu_mode;
    logic        alu_addr0;
    logic        alu_addr1;
    logic [7:0]  alu_rdata;
    logic        overrun;

    modport slave (
        input  cpu_m2, cpu_rw, cpu_addr, cpu_wdata, alu_rdata,
        output cpu_rdata, cpu_rdata_oe, alu_wdata, alu_wdata_oe,
               alu_mode, alu_addr0, alu_addr1, overrun
    );

    modport master (
        output cpu_m2, cpu_rw, cpu_addr, cpu_wdata, alu_rdata,
        input  cpu_rdata, cpu_rdata_oe, alu_wdata, alu_wdata_oe,
               alu_mode, alu_addr0, alu_addr1, overrun
    );
endinterface

// File: rtl/nintendo_alu_bus_if.sv
// CPU-bus front end for the protection ALU: decodes a two-address window, sequences
// writes into data + rising-edge strobes, and steers the ALU into output mode for reads.
module nintendo_alu_bus_if #(
    parameter logic [15:0] BASE_ADDR     = 16'h5000,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    nintendo_alu_bus_if_if.slave  bus
);
    localparam int unsigned CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] m2_sync;
    logic                   m2_s, m2_nx, m2_q, rise, fall;
    logic [15:0]            cap_addr;
    logic                   cap_rw;
    logic [7:0]             cap_wdata;
    logic                   wr_fire, live_rd, rd_go;
    logic                   load_new, load_pend, accept_pend, drop;
    logic                   pend_valid, pend_sel, cur_sel, read_pend;
    logic [7:0]             pend_data, cur_data, cpu_rdata_q;
    logic [CW-1:0]          cnt;
    logic                   oe_d, addr0_d, addr1_d, mode_d, rdata_oe_d;
    logic                   oe_q, addr0_q, addr1_q, mode_q, rdata_oe_q, overrun_q;

    assign m2_s  = m2_sync[SYNC_STAGES-1];
    assign m2_nx = m2_sync[SYNC_STAGES-2];
    assign rise  = m2_s & ~m2_q;
    assign fall  = ~m2_s & m2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m2_sync <= '0;
            m2_q    <= 1'b0;
        end else begin
            m2_sync <= {m2_sync[SYNC_STAGES-2:0], bus.cpu_m2};
            m2_q    <= m2_s;
        end
    end

    // Bus fields are tracked while m2 is high so the fall cycle sees the last valid sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_addr  <= '0;
            cap_rw    <= 1'b1;
            cap_wdata <= '0;
        end else if (m2_s) begin
            cap_addr  <= bus.cpu_addr;
            cap_rw    <= bus.cpu_rw;
            cap_wdata <= bus.cpu_wdata;
        end
    end

    assign wr_fire = fall & ~cap_rw & (cap_addr[15:1] == BASE_ADDR[15:1]);
    assign live_rd = rise & bus.cpu_rw & (bus.cpu_addr[15:1] == BASE_ADDR[15:1]);

    // A full slot being drained in HOLD still counts as full, so a write landing then is lost
    assign load_new    = wr_fire & (state == IDLE) & ~pend_valid;
    assign load_pend   = pend_valid & ((state == IDLE) | (state == HOLD));
    assign accept_pend = wr_fire & ~load_new & ~pend_valid;
    assign drop        = wr_fire & ~load_new & pend_valid;

    // Reads only start with the write path fully drained; alu_wdata_oe is then low next cycle
    assign rd_go = m2_s & m2_nx & (live_rd | read_pend) & (state == IDLE) & ~pend_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (load_pend || load_new) state_n = SETUP;
            SETUP:  state_n = STROBE;
            STROBE: if (cnt == CW'(STROBE_CYCLES - 1)) state_n = HOLD;
            HOLD:   state_n = pend_valid ? SETUP : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        oe_d       = (state_n != IDLE);
        addr0_d    = (state_n == STROBE) & ~cur_sel;
        addr1_d    = (state_n == STROBE) & cur_sel;
        mode_d     = ~rd_go;
        rdata_oe_d = rd_go;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oe_q       <= 1'b0;
            addr0_q    <= 1'b0;
            addr1_q    <= 1'b0;
            mode_q     <= 1'b1;
            rdata_oe_q <= 1'b0;
        end else begin
            oe_q       <= oe_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            mode_q     <= mode_d;
            rdata_oe_q <= rdata_oe_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            cur_sel     <= 1'b0;
            cur_data    <= '0;
            pend_valid  <= 1'b0;
            pend_sel    <= 1'b0;
            pend_data   <= '0;
            overrun_q   <= 1'b0;
            read_pend   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            if (state == STROBE) cnt <= cnt + CW'(1);
            else                 cnt <= '0;

            if (load_pend) begin
                cur_sel  <= pend_sel;
                cur_data <= pend_data;
            end else if (load_new) begin
                cur_sel  <= cap_addr[0];
                cur_data <= cap_wdata;
            end

            if (accept_pend) begin
                pend_valid <= 1'b1;
                pend_sel   <= cap_addr[0];
                pend_data  <= cap_wdata;
            end else if (load_pend) begin
                pend_valid <= 1'b0;
            end

            if (drop) overrun_q <= 1'b1;

            if (!m2_s)        read_pend <= 1'b0;
            else if (live_rd) read_pend <= 1'b1;

            if (!mode_q) cpu_rdata_q <= bus.alu_rdata;
        end
    end

    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.cpu_rdata_oe = rdata_oe_q;
    assign bus.alu_wdata    = cur_data;
    assign bus.alu_wdata_oe = oe_q;
    assign bus.alu_mode     = mode_q;
    assign bus.alu_addr0    = addr0_q;
    assign bus.alu_addr1    = addr1_q;
    assign bus.overrun      = overrun_q;
endmodule
